gpr_file_sb: RTL and testbench

GPR_FILE_SB -- requirements
Module: gpr_file_sb

---
 rtl/gpr_file_sb.sv | 113 +++++++++++
 tb/tb_gpr_file_sb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_file_sb.sv
// Register file with per-register busy (scoreboard) bits, two read ports and writeback bypass.
// Reads are zero-cycle combinational; writes, issues and busy_count update on the rising clk edge.
// No backpressure inputs; stall is advisory, the OR of the two read-port busy flags.
module gpr_file_sb #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 3,
   parameter int ZERO_REG = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              reg_write_en,
   input  logic [ADDR_W-1:0] reg_write_dest,
   input  logic [DATA_W-1:0] reg_write_data,
   input  logic              reg_issue_en,
   input  logic [ADDR_W-1:0] reg_issue_dest,
   input  logic [ADDR_W-1:0] reg_read_addr_1,
   output logic [DATA_W-1:0] reg_read_data_1,
   output logic              reg_read_busy_1,
   input  logic [ADDR_W-1:0] reg_read_addr_2,
   output logic [DATA_W-1:0] reg_read_data_2,
   output logic              reg_read_busy_2,
   output logic              stall,
   output logic [ADDR_W:0]   busy_count
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;
   logic [ADDR_W:0]   count_d;
   logic              wr_ok;
   logic              iss_ok;

   logic [ADDR_W-1:0] rd_addr [2];
   logic [DATA_W-1:0] rd_data [2];
   logic              rd_busy [2];

   // Index 0 is immune to writes and issues when it is the hardwired zero register.
   always_comb begin
      wr_ok  = reg_write_en;
      iss_ok = reg_issue_en;
      if (ZERO_REG != 0) begin
         if (reg_write_dest == '0) wr_ok  = 1'b0;
         if (reg_issue_dest == '0) iss_ok = 1'b0;
      end
   end

   // Next busy vector: writeback clears, issue sets afterwards so issue wins on the same index.
   always_comb begin
      busy_d = busy_q;
      if (wr_ok)  busy_d[reg_write_dest] = 1'b0;
      if (iss_ok) busy_d[reg_issue_dest] = 1'b1;
   end

   // Population count of the next busy vector, so the registered count tracks the bits exactly.
   always_comb begin
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         count_d = count_d + (ADDR_W+1)'(busy_d[i]);
      end
   end

   // Register data storage; cleared asynchronously, written on accepted writeback.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_ok) begin
         regs[reg_write_dest] <= reg_write_data;
      end
   end

   // Busy bits and their registered population count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q     <= '0;
         busy_count <= '0;
      end else begin
         busy_q     <= busy_d;
         busy_count <= count_d;
      end
   end

   assign rd_addr[0] = reg_read_addr_1;
   assign rd_addr[1] = reg_read_addr_2;

   // Per-port read: zero register, then writeback bypass, then stored state; all forced low in reset.
   for (genvar p = 0; p < 2; p++) begin : g_rd
      always_comb begin
         rd_data[p] = regs[rd_addr[p]];
         rd_busy[p] = busy_q[rd_addr[p]];
         if (!rst_n) begin
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
         end else if ((ZERO_REG != 0) && (rd_addr[p] == '0)) begin
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
         end else if (wr_ok && (reg_write_dest == rd_addr[p])) begin
            rd_data[p] = reg_write_data;
            rd_busy[p] = iss_ok && (reg_issue_dest == rd_addr[p]);
         end
      end
   end

   assign reg_read_data_1 = rd_data[0];
   assign reg_read_busy_1 = rd_busy[0];
   assign reg_read_data_2 = rd_data[1];
   assign reg_read_busy_2 = rd_busy[1];
   assign stall           = rd_busy[0] | rd_busy[1];

endmodule

// File: tb/tb_gpr_file_sb.sv
module tb_gpr_file_sb;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int n_run = 0;
   int n_fail = 0;

   typedef struct {
      string       tag;
      logic [63:0] exp;
   } exp_t;
   exp_t sb[$];

   // default instance: DATA_W=16, ADDR_W=3, ZERO_REG=0
   logic        a_we, a_ie, a_rb1, a_rb2, a_stall;
   logic [2:0]  a_wd, a_id, a_ra1, a_ra2;
   logic [15:0] a_wdat, a_rd1, a_rd2;
   logic [3:0]  a_cnt;

   // zero-register instance
   logic        z_we, z_ie, z_rb1, z_rb2, z_stall;
   logic [2:0]  z_wd, z_id, z_ra1, z_ra2;
   logic [15:0] z_wdat, z_rd1, z_rd2;
   logic [3:0]  z_cnt;

   // wide instance: DATA_W=32, ADDR_W=4
   logic        w_we, w_ie, w_rb1, w_rb2, w_stall;
   logic [3:0]  w_wd, w_id, w_ra1, w_ra2;
   logic [31:0] w_wdat, w_rd1, w_rd2;
   logic [4:0]  w_cnt;

   gpr_file_sb dut_a (
      .clk(clk), .rst_n(rst_n),
      .reg_write_en(a_we), .reg_write_dest(a_wd), .reg_write_data(a_wdat),
      .reg_issue_en(a_ie), .reg_issue_dest(a_id),
      .reg_read_addr_1(a_ra1), .reg_read_data_1(a_rd1), .reg_read_busy_1(a_rb1),
      .reg_read_addr_2(a_ra2), .reg_read_data_2(a_rd2), .reg_read_busy_2(a_rb2),
      .stall(a_stall), .busy_count(a_cnt)
   );

   gpr_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dut_z (
      .clk(clk), .rst_n(rst_n),
      .reg_write_en(z_we), .reg_write_dest(z_wd), .reg_write_data(z_wdat),
      .reg_issue_en(z_ie), .reg_issue_dest(z_id),
      .reg_read_addr_1(z_ra1), .reg_read_data_1(z_rd1), .reg_read_busy_1(z_rb1),
      .reg_read_addr_2(z_ra2), .reg_read_data_2(z_rd2), .reg_read_busy_2(z_rb2),
      .stall(z_stall), .busy_count(z_cnt)
   );

   gpr_file_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(0)) dut_w (
      .clk(clk), .rst_n(rst_n),
      .reg_write_en(w_we), .reg_write_dest(w_wd), .reg_write_data(w_wdat),
      .reg_issue_en(w_ie), .reg_issue_dest(w_id),
      .reg_read_addr_1(w_ra1), .reg_read_data_1(w_rd1), .reg_read_busy_1(w_rb1),
      .reg_read_addr_2(w_ra2), .reg_read_data_2(w_rd2), .reg_read_busy_2(w_rb2),
      .stall(w_stall), .busy_count(w_cnt)
   );

   task automatic push(input string tag, input logic [63:0] e);
      exp_t x;
      x.tag = tag;
      x.exp = e;
      sb.push_back(x);
   endtask

   task automatic chk(input logic [63:0] obs);
      exp_t e;
      n_run++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL sb_empty: observed %0h with no expectation queued", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
         end
      end
   endtask

   initial begin
      {a_we, a_wd, a_wdat, a_ie, a_id, a_ra1, a_ra2} = '0;
      {z_we, z_wd, z_wdat, z_ie, z_id, z_ra1, z_ra2} = '0;
      {w_we, w_wd, w_wdat, w_ie, w_id, w_ra1, w_ra2} = '0;

      // reset state, with a write pending to show the bypass is suppressed
      #2 rst_n = 1'b0;
      a_we = 1'b1; a_wd = 3'd0; a_wdat = 16'hBEEF;
      #1;
      push("rst_cnt", 64'd0);    chk(64'(a_cnt));
      push("rst_data1", 64'd0);  chk(64'(a_rd1));
      push("rst_busy1", 64'd0);  chk(64'(a_rb1));
      push("rst_stall", 64'd0);  chk(64'(a_stall));
      push("rst_wcnt", 64'd0);   chk(64'(w_cnt));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      a_we = 1'b0;
      #1;
      push("rst_discard", 64'd0); chk(64'(a_rd1));

      // write i+100 to reg i, checking bypass on port 1 in the same cycle
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         a_we = 1'b1; a_wd = 3'(i); a_wdat = 16'(i + 100); a_ra1 = 3'(i);
         #1;
         push($sformatf("bypass_d%0d", i), 64'(i + 100)); chk(64'(a_rd1));
      end
      @(negedge clk);
      a_we = 1'b0;
      for (int i = 0; i < 8; i++) begin
         a_ra1 = 3'(i); a_ra2 = 3'(i);
         #1;
         push($sformatf("rd1_%0d", i), 64'(i + 100)); chk(64'(a_rd1));
         push($sformatf("rd2_%0d", i), 64'(i + 100)); chk(64'(a_rd2));
         push($sformatf("busy_%0d", i), 64'd0);       chk(64'({a_rb1, a_rb2}));
      end

      // issue 3, then resolve it by writeback
      @(negedge clk);
      a_ie = 1'b1; a_id = 3'd3;
      @(negedge clk);
      a_ie = 1'b0; a_ra1 = 3'd3; a_ra2 = 3'd0;
      #1;
      push("iss3_busy1", 64'd1); chk(64'(a_rb1));
      push("iss3_stall", 64'd1); chk(64'(a_stall));
      push("iss3_cnt", 64'd1);   chk(64'(a_cnt));
      @(negedge clk);
      a_we = 1'b1; a_wd = 3'd3; a_wdat = 16'h00AA;
      #1;
      push("wb3_data", 64'h00AA); chk(64'(a_rd1));
      push("wb3_busy", 64'd0);    chk(64'(a_rb1));
      push("wb3_stall", 64'd0);   chk(64'(a_stall));
      push("wb3_cnt_old", 64'd1); chk(64'(a_cnt));
      @(negedge clk);
      a_we = 1'b0;
      #1;
      push("wb3_cnt", 64'd0);     chk(64'(a_cnt));
      push("wb3_held", 64'h00AA); chk(64'(a_rd1));

      // issue and write reg 5 together: issue wins
      @(negedge clk);
      a_we = 1'b1; a_wd = 3'd5; a_wdat = 16'h1234; a_ie = 1'b1; a_id = 3'd5;
      a_ra1 = 3'd5; a_ra2 = 3'd6;
      #1;
      push("iw5_byp_data", 64'h1234); chk(64'(a_rd1));
      push("iw5_byp_busy", 64'd1);    chk(64'(a_rb1));
      @(negedge clk);
      a_we = 1'b0; a_ie = 1'b0;
      #1;
      push("iw5_data", 64'h1234); chk(64'(a_rd1));
      push("iw5_busy", 64'd1);    chk(64'(a_rb1));
      push("iw5_cnt", 64'd1);     chk(64'(a_cnt));

      // write 5 and issue 6 together: both take effect
      @(negedge clk);
      a_we = 1'b1; a_wd = 3'd5; a_wdat = 16'h0077; a_ie = 1'b1; a_id = 3'd6;
      @(negedge clk);
      a_we = 1'b0; a_ie = 1'b0;
      #1;
      push("w5i6_data5", 64'h0077); chk(64'(a_rd1));
      push("w5i6_busy5", 64'd0);    chk(64'(a_rb1));
      push("w5i6_busy6", 64'd1);    chk(64'(a_rb2));
      push("w5i6_cnt", 64'd1);      chk(64'(a_cnt));

      // zero register instance: write/issue to reg 0 ignored
      @(negedge clk);
      z_we = 1'b1; z_wd = 3'd1; z_wdat = 16'h0011; z_ie = 1'b1; z_id = 3'd2;
      @(negedge clk);
      z_we = 1'b1; z_wd = 3'd0; z_wdat = 16'hFFFF; z_ie = 1'b1; z_id = 3'd0;
      z_ra1 = 3'd0; z_ra2 = 3'd0;
      #1;
      push("z0_byp_data", 64'd0); chk(64'(z_rd1));
      push("z0_byp_busy", 64'd0); chk(64'(z_rb2));
      push("z0_cnt_pre", 64'd1);  chk(64'(z_cnt));
      @(negedge clk);
      z_we = 1'b0; z_ie = 1'b0;
      #1;
      push("z0_data", 64'd0);      chk(64'(z_rd2));
      push("z0_busy", 64'd0);      chk(64'(z_rb1));
      push("z0_stall", 64'd0);     chk(64'(z_stall));
      push("z0_cnt", 64'd1);       chk(64'(z_cnt));
      z_ra1 = 3'd1;
      #1;
      push("z1_data", 64'h0011);   chk(64'(z_rd1));

      // wide instance: 32-bit data, 16 registers
      @(negedge clk);
      w_we = 1'b1; w_wd = 4'd15; w_wdat = 32'hDEADBEEF;
      @(negedge clk);
      w_we = 1'b0; w_ra2 = 4'd15;
      #1;
      push("w15_data2", 64'hDEADBEEF); chk(64'(w_rd2));
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         w_ie = 1'b1; w_id = 4'(i);
      end
      @(negedge clk);
      w_ie = 1'b0;
      #1;
      push("w_cnt16", 64'd16); chk(64'(w_cnt));
      push("w_busy15", 64'd1); chk(64'(w_rb2));

      // issue 1,2,4 on top of pending 6, then reset mid-clock
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a_ie = 1'b1; a_id = (i == 2) ? 3'd4 : 3'(i + 1);
      end
      @(negedge clk);
      a_ie = 1'b0; a_ra1 = 3'd2; a_ra2 = 3'd4;
      #1;
      push("pre_rst_cnt", 64'd4);   chk(64'(a_cnt));
      push("pre_rst_data", 64'd102); chk(64'(a_rd1));
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      push("mid_rst_cnt", 64'd0);   chk(64'(a_cnt));
      push("mid_rst_data1", 64'd0); chk(64'(a_rd1));
      push("mid_rst_busy2", 64'd0); chk(64'(a_rb2));
      push("mid_rst_wcnt", 64'd0);  chk(64'(w_cnt));
      // a write held across a reset edge must be discarded
      a_we = 1'b1; a_wd = 3'd7; a_wdat = 16'h0099; a_ra1 = 3'd7;
      #1;
      push("rst_no_bypass", 64'd0); chk(64'(a_rd1));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      a_we = 1'b0;
      #1;
      push("post_rst_d7", 64'd0);   chk(64'(a_rd1));
      push("post_rst_d4", 64'd0);   chk(64'(a_rd2));
      push("post_rst_busy", 64'd0); chk(64'(a_stall));
      push("post_rst_cnt", 64'd0);  chk(64'(a_cnt));
      @(negedge clk);
      a_we = 1'b1; a_wd = 3'd7; a_wdat = 16'h0042;
      @(negedge clk);
      a_we = 1'b0;
      #1;
      push("post_rst_wr7", 64'h0042); chk(64'(a_rd1));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
